// File: rtl/add_seq_arb.sv
// Round-robin arbiter and nibble-serial sequencer for a shared external 4-bit adder.
// Two requesters share one WIDTH-bit add engine; results return on a valid/ready port.
module add_seq_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic [3:0]       add_x,
  output logic [3:0]       add_y,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic [WIDTH-1:0]  sum_r;
  logic              carry;
  logic              id;
  logic              prio;
  logic              cout_r;
  logic              grant0;
  logic              grant1;

  // Constant-index nibble mux keeps every select in range for any legal WIDTH.
  function automatic logic [3:0] nibble_at(input logic [WIDTH-1:0] vec,
                                           input logic [CW-1:0] idx);
    nibble_at = 4'd0;
    for (int i = 0; i < N; i++) begin
      if (idx == CW'(i)) begin
        nibble_at = vec[4*i +: 4];
      end
    end
  endfunction

  // Round-robin grant: a lone requester wins, ties go to prio.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = ~prio;
      grant1 = prio;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Ready is gated by rst_n so nothing looks accepted while reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && (state == IDLE)) begin
      req0_ready = grant0;
      req1_ready = grant1;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  // Shared adder sees the current nibble only while running, zeros otherwise.
  always_comb begin
    add_x   = 4'd0;
    add_y   = 4'd0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_x   = nibble_at(opa, cnt);
      add_y   = nibble_at(opb, cnt);
      add_cin = carry;
    end else begin
      add_x   = 4'd0;
      add_y   = 4'd0;
      add_cin = 1'b0;
    end
  end

  // Sequencer FSM: accept, ripple N nibbles through the adder, hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= {CW{1'b0}};
      opa    <= {WIDTH{1'b0}};
      opb    <= {WIDTH{1'b0}};
      sum_r  <= {WIDTH{1'b0}};
      carry  <= 1'b0;
      id     <= 1'b0;
      prio   <= 1'b0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant1) begin
            opa   <= req1_a;
            opb   <= req1_b;
            carry <= req1_cin;
            id    <= 1'b1;
            prio  <= 1'b0;
            cnt   <= {CW{1'b0}};
            state <= RUN;
          end else if (grant0) begin
            opa   <= req0_a;
            opb   <= req0_b;
            carry <= req0_cin;
            id    <= 1'b0;
            prio  <= 1'b1;
            cnt   <= {CW{1'b0}};
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
              sum_r[4*i +: 4] <= add_sum;
            end
          end
          carry <= add_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout_r <= add_cout;
            state  <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = (state == DONE);
  assign rsp_sum   = sum_r;
  assign rsp_cout  = cout_r;
  assign rsp_id    = id;

endmodule

// File: tb/tb_add_seq_arb.sv
// Bench for add_seq_arb: cycle model with arithmetic expectations for WIDTH=16,
// directed literal cases, randomized traffic, and an exhaustive WIDTH=4 sweep.
module tb_add_seq_arb;
  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0_valid, req0_ready, req0_cin;
  logic [W-1:0]  req0_a, req0_b;
  logic          req1_valid, req1_ready, req1_cin;
  logic [W-1:0]  req1_a, req1_b;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [W-1:0]  rsp_sum;
  logic [3:0]    add_x, add_y, add_sum;
  logic          add_cin, add_cout;

  add_seq_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );
  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {4'd0, add_cin};

  // WIDTH=4 instance for the exhaustive sweep
  logic       v4, r4, cin4, rv4, rr4, rid4, rc4, ac4, aco4;
  logic [3:0] a4, b4, rs4, ax4, ay4, as4;
  logic       u_v1, u_r1, u_c1;
  logic [3:0] u_a1, u_b1;
  add_seq_arb #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v4), .req0_ready(r4), .req0_a(a4), .req0_b(b4), .req0_cin(cin4),
    .req1_valid(u_v1), .req1_ready(u_r1), .req1_a(u_a1), .req1_b(u_b1), .req1_cin(u_c1),
    .rsp_valid(rv4), .rsp_ready(rr4), .rsp_id(rid4), .rsp_sum(rs4), .rsp_cout(rc4),
    .add_x(ax4), .add_y(ay4), .add_cin(ac4), .add_sum(as4), .add_cout(aco4)
  );
  assign {aco4, as4} = {1'b0, ax4} + {1'b0, ay4} + {4'd0, ac4};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 computing (step nibbles done), 2 result held
  int         ph = 0;
  int         step = 0;
  logic       mprio = 1'b0;
  logic [W-1:0] ma = '0, mb = '0;
  logic       mcin = 1'b0, mid = 1'b0;
  bit         acc0 = 0, acc1 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; step = 0; mprio = 1'b0; acc0 = 0; acc1 = 0;
    end else begin
      acc0 = 0; acc1 = 0;
      if (ph == 0) begin
        if (req0_valid || req1_valid) begin
          mid = (req0_valid && req1_valid) ? mprio : req1_valid;
          if (mid) begin ma = req1_a; mb = req1_b; mcin = req1_cin; acc1 = 1; end
          else     begin ma = req0_a; mb = req0_b; mcin = req0_cin; acc0 = 1; end
          mprio = ~mid;
          ph = 1; step = 0;
        end
      end else if (ph == 1) begin
        step++;
        if (step == N) ph = 2;
      end else begin
        if (rsp_ready) ph = 0;
      end
    end
  end

  bit cmp_en = 0;

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    logic        any, g;
    logic [31:0] full, lo, msk;
    int          sh;
    if (cmp_en) begin
      any = req0_valid | req1_valid;
      g   = (req0_valid && req1_valid) ? mprio : req1_valid;
      check("req0_ready", 32'(req0_ready), 32'(rst_n && ph == 0 && any && !g));
      check("req1_ready", 32'(req1_ready), 32'(rst_n && ph == 0 && any && g));
      check("rsp_valid", 32'(rsp_valid), 32'(ph == 2));
      if (ph == 1) begin
        sh  = 4 * step;
        msk = (32'd1 << sh) - 32'd1;
        lo  = ({16'd0, ma} & msk) + ({16'd0, mb} & msk) + 32'(mcin);
        check("add_x", 32'(add_x), ({16'd0, ma} >> sh) & 32'hF);
        check("add_y", 32'(add_y), ({16'd0, mb} >> sh) & 32'hF);
        check("add_cin", 32'(add_cin), (lo >> sh) & 32'd1);
      end else begin
        check("add_idle", {23'd0, add_x, add_y, add_cin}, 32'd0);
      end
      if (ph == 2) begin
        full = 32'(ma) + 32'(mb) + 32'(mcin);
        check("rsp_sum", 32'(rsp_sum), full & 32'hFFFF);
        check("rsp_cout", 32'(rsp_cout), (full >> 16) & 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(mid));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One directed request with literal expectations and latency check
  task automatic run_one(input logic who, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [W-1:0] es, input logic ec);
    int k;
    rsp_ready = 1'b1;
    if (who) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; end
    else     begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; end
    for (k = 0; k < 20; k++) begin
      if (who ? req1_ready : req0_ready) break;
      tick();
    end
    check("accept_wait", 32'(who ? req1_ready : req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin tick(); k++; end
    check("latency", 32'(k), 32'(N));
    check("lit_sum", 32'(rsp_sum), 32'(es));
    check("lit_cout", 32'(rsp_cout), 32'(ec));
    check("lit_id", 32'(rsp_id), 32'(who));
    tick();
  endtask

  initial begin
    int      k;
    logic [3:0] ids;
    logic [W-1:0] held;
    logic [4:0] exp5;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp_ready = 1'b1;
    v4 = 1'b0; a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0; rr4 = 1'b1;
    u_v1 = 1'b0; u_a1 = 4'd0; u_b1 = 4'd0; u_c1 = 1'b0;

    // Reset state, with a request pending that must not look accepted
    req0_valid = 1'b1;
    #2;
    check("rst_outputs", {rsp_valid, rsp_id, rsp_cout, rsp_sum, add_x, add_y, add_cin, req0_ready, req1_ready}, 32'd0);
    req0_valid = 1'b0;
    #20 rst_n = 1'b1;
    cmp_en = 1;
    tick();

    run_one(1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0);
    run_one(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_one(1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0);

    // Reset mid-RUN at cnt==2
    req0_valid = 1'b1; req0_a = 16'hABCD; req0_b = 16'h1111; req0_cin = 1'b0;
    while (!req0_ready) tick();
    tick();
    req0_valid = 1'b0;
    tick(); tick();
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_addx", 32'(add_x), 32'd0);
    check("mid_rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    req1_valid = 1'b0;
    #3 rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (rsp_valid) k++; end
    check("aborted_no_rsp", 32'(k), 32'd0);

    // Contention after reset: grants alternate starting with requester 0
    req0_valid = 1'b1; req0_a = 16'h0101; req0_b = 16'h0202; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1'b1;
    k = 0; ids = 4'd0;
    for (int c = 0; c < 100 && k < 4; c++) begin
      if (rsp_valid) begin
        ids[k] = rsp_id; k++;
        if (k == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
      tick();
    end
    check("contention_ids", {28'd0, ids}, 32'hA);
    tick();

    // Backpressure: result held 5 cycles while req1 waits
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h7777; req0_b = 16'h1111; req0_cin = 1'b1;
    for (k = 0; k < 20 && !req0_ready; k++) tick();
    tick();
    req0_valid = 1'b0;
    for (k = 0; k < 20 && !rsp_valid; k++) tick();
    held = rsp_sum;
    check("bp_lit_sum", 32'(held), 32'h8889);
    req1_valid = 1'b1; req1_a = 16'h0003; req1_b = 16'h0004; req1_cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_sum_stable", 32'(rsp_sum), 32'(held));
      check("bp_req1_ready", 32'(req1_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_req1_accept", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1'b1;
        req0_a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        req0_b = 16'($urandom); req0_cin = 1'($urandom);
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1'b1;
        req1_a = 16'($urandom);
        req1_b = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
        req1_cin = 1'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    // Exhaustive WIDTH=4 sweep
    for (int ci = 0; ci < 2; ci++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          v4 = 1'b1; a4 = 4'(a); b4 = 4'(b); cin4 = 1'(ci);
          for (k = 0; k < 10 && !r4; k++) tick();
          tick();
          v4 = 1'b0;
          for (k = 0; k < 10 && !rv4; k++) tick();
          exp5 = 5'(a + b + ci);
          check("w4_sum", {27'd0, rc4, rs4}, {27'd0, exp5});
          tick();
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/add_seq_arb.md
# add_seq_arb

Sequencer and two-port arbiter for the shared 4-bit ripple adder.

- Accepts WIDTH-bit add requests from two requesters, selecting between them round-robin.
- Computes each sum nibble-serially on the single external 4-bit adder, least-significant nibble first, chaining the carry through a register.
- Returns the full sum, carry-out and requester ID on a valid/ready response port.
- Sits between the requesting datapaths and the combinational adder (ports x, y, c_in, sum, c_out).

## Interface
- WIDTH, 16: operand width. Must be a multiple of 4 and ≥ 4. N = WIDTH/4 nibble steps.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has a request; held with data until accepted.
- req0_ready  out  1  request 0 accepted on this edge when req0_valid is also high.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as the req0 signals, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that issued this result.
- rsp_sum  out  WIDTH  sum.
- rsp_cout  out  1  carry out of the MSB nibble.
- add_x, add_y  out  4  operand nibbles to the shared adder.
- add_cin  out  1  carry into the shared adder.
- add_sum  in  4  adder sum, combinational.
- add_cout  in  1  adder carry-out, combinational.

## Operation
- Registers:
  - state: IDLE, RUN, DONE.
  - cnt: ceil(log2 N) bits.
  - opa, opb: WIDTH bits each.
  - carry.
  - id.
  - prio: round-robin pointer, 1 bit.
  - sum_r: WIDTH bits.
- IDLE:
  - Grant goes to the only valid requester. If both are valid, grant goes to requester prio.
  - reqX_ready = (state==IDLE) & grantX (combinational). Never both high.
  - On acceptance: capture a, b, cin into opa, opb, carry; id <= X; prio <= ~X; cnt <= 0; state -> RUN.
  - With no valid request, state stays IDLE and prio is unchanged.
- RUN:
  - Adder drive: add_x = opa[4*cnt+3 : 4*cnt], add_y = opb[same slice], add_cin = carry.
  - Each edge: sum_r[4*cnt+3 : 4*cnt] <= add_sum; carry <= add_cout; cnt <= cnt+1.
  - When cnt == N-1: state -> DONE; rsp_cout takes the final add_cout.
- DONE:
  - rsp_valid = 1. rsp_sum, rsp_cout and rsp_id are stable while rsp_valid is high.
  - On rsp_valid & rsp_ready: state -> IDLE.
  - No request is accepted while in RUN or DONE.
- Outside RUN: add_x = 0, add_y = 0, add_cin = 0, so the shared adder sees a quiet input.
- Arithmetic is modulo 2^WIDTH. Carry-out is reported only via rsp_cout; no overflow flag.
- Reset (asynchronous, any state):
  - state = IDLE, prio = 0, cnt = 0, carry = 0, id = 0, sum_r = 0.
  - All outputs 0.
  - An in-flight operation is discarded with no response.

## Timing
- Acceptance edge t0. Nibble i is registered at edge t0+i+1.
- rsp_valid rises after edge t0+N, i.e. N cycles after acceptance (4 for WIDTH=16).
- If rsp_ready is high throughout, the response transfers at edge t0+N+1 and state returns to IDLE.
- The next acceptance is possible no earlier than edge t0+N+2. Peak throughput is one operation per N+2 cycles.
- rsp_ready low holds DONE indefinitely. The response is not lost and no new request is accepted.
- Request-side and response-side events cannot overlap, because acceptance happens only in IDLE.
- Adder path: add_* outputs → external adder → add_sum/add_cout → registers, all within one clk period.

## Test plan
- Basic add, WIDTH=16: req0 a=0x1234, b=0x0FCD, cin=0.
  - Response: rsp_sum=0x2201, rsp_cout=0, rsp_id=0.
  - rsp_valid rises exactly 4 cycles after acceptance.
- Carry rippling through every nibble:
  - a=0xFFFF, b=0x0001, cin=0 → rsp_sum=0x0000, rsp_cout=1.
  - a=0x00FF, b=0x0000, cin=1 → rsp_sum=0x0100, rsp_cout=0.
- Contention: after reset, req0 and req1 both valid and held continuously.
  - Grants alternate 0,1,0,1, so rsp_id sequence is 0,1,0,1.
  - Never two readys in the same cycle.
- Backpressure: hold rsp_ready low for 5 cycles with req1 valid.
  - rsp_valid and rsp_sum are stable throughout; req1_ready stays 0.
  - Raising rsp_ready transfers the result; req1 is accepted 1 cycle later.
- Reset mid-RUN: assert rst_n=0 at cnt=2.
  - Immediately, with no clock edge: rsp_valid=0, add_x=0, reqX_ready=0.
  - After release the block is in IDLE with prio=0. The aborted operation produces no response.
- Exhaustive adder-drive check, WIDTH=4 instance:
  - All 256 a/b pairs with cin=0, plus the same pairs with cin=1.
  - Each result equals a+b+cin in 5 bits, checked as {rsp_cout, rsp_sum}.
